// File: rtl/mem_fifo.sv
// mem_fifo: synchronous single-clock FIFO with registered status flags,
// sticky overflow/underflow error flags and a selectable read mode.
//
// Parameters:
//   DATA_W  word width in bits
//   ADDR_W  log2 of depth (DEPTH = 2**ADDR_W)
//   AF_LVL  almost-full threshold  (almost_full  = count >= AF_LVL)
//   AE_LVL  almost-empty threshold (almost_empty = count <= AE_LVL)
//   FWFT    0 = registered read (rdata one cycle after rd),
//           1 = first-word-fall-through (rdata shows head word, rd pops)
//
// Ports:
//   clk          sole clock, rising edge
//   resetn       synchronous active-low reset
//   wr, wdata    write request and data
//   rd           read request (pop/acknowledge in FWFT mode)
//   clr_err      clears overflow/underflow
//   rdata,rvalid read data and its valid flag
//   empty, full, almost_full, almost_empty, count   registered status
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module mem_fifo #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_C = PW'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C = PW'(AE_LVL);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]   wptr_r;
    logic [ADDR_W:0]   rptr_r;
    logic [ADDR_W:0]   count_r;
    logic              empty_r;
    logic              full_r;
    logic              almost_full_r;
    logic              almost_empty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic [DATA_W-1:0] rdata_r;
    logic              rvalid_r;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [ADDR_W:0]   wptr_nxt_s;
    logic [ADDR_W:0]   rptr_nxt_s;
    logic [ADDR_W:0]   count_nxt_s;
    logic              empty_nxt_s;
    logic              full_nxt_s;
    logic [DATA_W-1:0] head_nxt_s;

    // Acceptance decisions and next-state pointer/status values.
    always_comb begin
        wr_acc_s    = wr && !full_r;
        rd_acc_s    = rd && !empty_r;
        wptr_nxt_s  = wr_acc_s ? (wptr_r + PW'(1)) : wptr_r;
        rptr_nxt_s  = rd_acc_s ? (rptr_r + PW'(1)) : rptr_r;
        // Modular subtraction of the wrap-bit pointers gives 0..DEPTH.
        count_nxt_s = wptr_nxt_s - rptr_nxt_s;
        empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
        full_nxt_s  = (wptr_nxt_s[ADDR_W-1:0] == rptr_nxt_s[ADDR_W-1:0]) &&
                      (wptr_nxt_s[ADDR_W] != rptr_nxt_s[ADDR_W]);
        // Head word after this edge; a word being written this cycle that
        // lands on the new head is forwarded since storage is not yet updated.
        if (wr_acc_s && (wptr_r[ADDR_W-1:0] == rptr_nxt_s[ADDR_W-1:0])) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rptr_nxt_s[ADDR_W-1:0]];
        end
    end

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[ADDR_W-1:0]] <= wdata;
        end
    end

    // Pointers, registered status flags and sticky error flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_r         <= '0;
            rptr_r         <= '0;
            count_r        <= '0;
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wptr_r         <= wptr_nxt_s;
            rptr_r         <= rptr_nxt_s;
            count_r        <= count_nxt_s;
            empty_r        <= empty_nxt_s;
            full_r         <= full_nxt_s;
            almost_full_r  <= (count_nxt_s >= AF_C);
            almost_empty_r <= (count_nxt_s <= AE_C);
            // A new rejection in the clearing cycle takes priority.
            if (wr && full_r) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rd && empty_r) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    // Read data path: popped word pulse (FWFT=0) or registered head word (FWFT=1).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else if (FWFT != 0) begin
            rdata_r  <= head_nxt_s;
            rvalid_r <= !empty_nxt_s;
        end else if (rd_acc_s) begin
            rdata_r  <= mem_r[rptr_r[ADDR_W-1:0]];
            rvalid_r <= 1'b1;
        end else begin
            rdata_r  <= rdata_r;
            rvalid_r <= 1'b0;
        end
    end

    assign rdata        = rdata_r;
    assign rvalid       = rvalid_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_mem_fifo.sv
// tb_mem_fifo: directed self-checking bench. Instance a uses the default
// registered-read configuration; instance b uses FWFT=1 with 8-bit words.
module tb_mem_fifo;

    logic         clk;
    logic         resetn;
    logic         a_wr, a_rd, a_clr;
    logic [511:0] a_wdata;
    logic [511:0] a_rdata;
    logic         a_rvalid, a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
    logic [4:0]   a_count;

    logic         b_wr, b_rd, b_clr;
    logic [7:0]   b_wdata;
    logic [7:0]   b_rdata;
    logic         b_rvalid, b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
    logic [4:0]   b_count;

    int total_cnt = 0;
    int fail_cnt  = 0;

    mem_fifo u_a (
        .clk(clk), .resetn(resetn), .wr(a_wr), .wdata(a_wdata), .rd(a_rd),
        .clr_err(a_clr), .rdata(a_rdata), .rvalid(a_rvalid), .empty(a_empty),
        .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    mem_fifo #(.DATA_W(8), .FWFT(1)) u_b (
        .clk(clk), .resetn(resetn), .wr(b_wr), .wdata(b_wdata), .rd(b_rd),
        .clr_err(b_clr), .rdata(b_rdata), .rvalid(b_rvalid), .empty(b_empty),
        .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_wdata = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_wdata = 8'h00;
        tick();
        // Reset state
        chk("rst_count", 512'(a_count), 512'd0);
        chk("rst_empty", 512'(a_empty), 512'd1);
        chk("rst_full", 512'(a_full), 512'd0);
        chk("rst_af", 512'(a_af), 512'd0);
        chk("rst_ae", 512'(a_ae), 512'd1);
        chk("rst_rvalid", 512'(a_rvalid), 512'd0);
        chk("rst_rdata", a_rdata, 512'd0);
        chk("rst_ovf", 512'(a_ovf), 512'd0);
        chk("rst_unf", 512'(a_unf), 512'd0);
        chk("rst_b_empty", 512'(b_empty), 512'd1);
        resetn = 1'b1;

        // Fill with 0..15
        for (int i = 0; i < 16; i++) begin
            a_wr = 1'b1; a_wdata = 512'(i);
            tick();
            chk("fill_count", 512'(a_count), 512'(i + 1));
            chk("fill_af", 512'(a_af), 512'((i + 1) >= 12));
            chk("fill_ae", 512'(a_ae), 512'((i + 1) <= 4));
            chk("fill_full", 512'(a_full), 512'(i == 15));
        end
        // 17th write is rejected
        a_wdata = 512'h99;
        tick();
        chk("ovf_set", 512'(a_ovf), 512'd1);
        chk("ovf_count", 512'(a_count), 512'd16);
        a_wr = 1'b0; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("ovf_clr", 512'(a_ovf), 512'd0);

        // Drain 16 words in order
        for (int i = 0; i < 16; i++) begin
            a_rd = 1'b1;
            tick();
            chk("drain_rdata", a_rdata, 512'(i));
            chk("drain_rvalid", 512'(a_rvalid), 512'd1);
            chk("drain_count", 512'(a_count), 512'(15 - i));
        end
        chk("drain_empty", 512'(a_empty), 512'd1);
        tick();
        chk("unf_set", 512'(a_unf), 512'd1);
        chk("unf_rvalid", 512'(a_rvalid), 512'd0);
        chk("unf_rdata_hold", a_rdata, 512'd15);
        a_rd = 1'b0; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("unf_clr", 512'(a_unf), 512'd0);

        // Preload 5, then simultaneous read/write for 40 cycles
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1; a_wdata = 512'(100 + i);
            tick();
        end
        chk("pre5_count", 512'(a_count), 512'd5);
        for (int k = 0; k < 40; k++) begin
            a_wr = 1'b1; a_rd = 1'b1; a_wdata = 512'(105 + k);
            tick();
            chk("rw_count", 512'(a_count), 512'd5);
            chk("rw_rdata", a_rdata, 512'(100 + k));
        end
        a_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rw_tail", a_rdata, 512'(140 + i));
        end
        a_rd = 1'b0;
        tick();
        chk("rw_empty", 512'(a_empty), 512'd1);

        // rd+wr while empty: write wins, read rejected
        a_wr = 1'b1; a_rd = 1'b1; a_wdata = 512'h3C;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
        chk("emp_rw_count", 512'(a_count), 512'd1);
        chk("emp_rw_unf", 512'(a_unf), 512'd1);
        chk("emp_rw_rvalid", 512'(a_rvalid), 512'd0);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("emp_rw_clr", 512'(a_unf), 512'd0);

        // Reach count 9, then reset with a write pending
        for (int i = 0; i < 8; i++) begin
            a_wr = 1'b1; a_wdata = 512'(200 + i);
            tick();
        end
        chk("pre9_count", 512'(a_count), 512'd9);
        resetn = 1'b0; a_wdata = 512'h55;
        tick();
        resetn = 1'b1; a_wr = 1'b0;
        chk("mid_rst_count", 512'(a_count), 512'd0);
        chk("mid_rst_empty", 512'(a_empty), 512'd1);
        chk("mid_rst_ovf", 512'(a_ovf), 512'd0);
        chk("mid_rst_rvalid", 512'(a_rvalid), 512'd0);
        a_wr = 1'b1; a_wdata = 512'h77;
        tick();
        a_wr = 1'b0; a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        chk("post_rst_rdata", a_rdata, 512'h77);
        chk("post_rst_rvalid", 512'(a_rvalid), 512'd1);
        tick();
        chk("post_rst_empty", 512'(a_empty), 512'd1);
        chk("post_rst_rvalid0", 512'(a_rvalid), 512'd0);

        // FWFT instance
        b_wr = 1'b1; b_wdata = 8'hA5;
        tick();
        b_wr = 1'b0;
        chk("fwft_rdata", 512'(b_rdata), 512'hA5);
        chk("fwft_rvalid", 512'(b_rvalid), 512'd1);
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        chk("fwft_pop_empty", 512'(b_empty), 512'd1);
        chk("fwft_pop_rvalid", 512'(b_rvalid), 512'd0);
        b_wr = 1'b1; b_wdata = 8'h11;
        tick();
        b_wdata = 8'h22;
        tick();
        b_wr = 1'b0;
        chk("fwft_head", 512'(b_rdata), 512'h11);
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        chk("fwft_next", 512'(b_rdata), 512'h22);
        chk("fwft_count", 512'(b_count), 512'd1);

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_fifo.md
MEM_FIFO -- requirements
Module: mem_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 512, word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 4, log2 of depth; DEPTH = 2**ADDR_W; legal range 1..16.
REQ-003 SHALL provide parameter AF_LVL, default 12, almost-full threshold; legal when AE_LVL < AF_LVL <= DEPTH.
REQ-004 SHALL provide parameter AE_LVL, default 4, almost-empty threshold.
REQ-005 SHALL provide parameter FWFT, default 0; 0 = registered read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have one clock and a synchronous, active-low reset; ports follow.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 resetn  in  1  synchronous active-low reset.
REQ-009 wr  in  1  write request.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 rd  in  1  read request (FWFT=1: pop/acknowledge).
REQ-012 clr_err  in  1  clears sticky error flags.
REQ-013 rdata  out  DATA_W  read data.
REQ-014 rvalid  out  1  rdata valid.
REQ-015 empty  out  1  count == 0.
REQ-016 full  out  1  count == DEPTH.
REQ-017 almost_full  out  1  count >= AF_LVL.
REQ-018 almost_empty  out  1  count <= AE_LVL.
REQ-019 count  out  ADDR_W+1  stored word count, 0..DEPTH.
REQ-020 overflow  out  1  sticky: a write was rejected.
REQ-021 underflow  out  1  sticky: a read was rejected.

Function
REQ-022 Storage SHALL be DEPTH x DATA_W; write and read pointers ADDR_W+1 bits wide; low ADDR_W bits address storage; MSB is wrap bit.
REQ-023 empty SHALL be pointers equal; full SHALL be low bits equal and wrap bits different; count SHALL be (wptr - rptr) mod 2**(ADDR_W+1).
REQ-024 A write SHALL be accepted iff wr=1 and full=0, independent of rd; on acceptance wdata stored at wptr and wptr increments at that edge.
REQ-025 A read SHALL be accepted iff rd=1 and empty=0, independent of wr; on acceptance rptr increments at that edge.
REQ-026 Pointers SHALL wrap from 2**(ADDR_W+1)-1 to 0 without gaps; data order SHALL be strictly first-in first-out.
REQ-027 Simultaneous accepted read and write SHALL leave count unchanged; rd+wr when full: read accepted, write rejected; rd+wr when empty: write accepted, read rejected.
REQ-028 All status outputs (empty, full, almost_*, count) SHALL be registered, reflecting state after the most recent edge.
REQ-029 FWFT=0: accepted read at edge N SHALL drive rdata = popped word and rvalid=1 for one cycle after edge N; otherwise rvalid=0 and rdata holds its last value.
REQ-030 FWFT=1: rdata SHALL present the word at rptr and rvalid = !empty; a word written at edge N SHALL appear with rvalid=1 after edge N.
REQ-031 Rejected write SHALL set overflow; rejected read SHALL set underflow; both stay set until clr_err=1 at an edge; a new set event in the clearing cycle SHALL win.

Reset
REQ-032 At a rising edge with resetn=0: pointers, count, overflow, underflow, rvalid SHALL go 0; empty=1, almost_empty=1, full=0, almost_full=0; rdata=0 in FWFT=0.
REQ-033 Storage array SHALL NOT be cleared; reset mid-operation SHALL discard all stored words; wr/rd during reset SHALL be ignored.
REQ-034 resetn changes between edges SHALL have no effect until the next edge.

Verification (defaults unless stated)
REQ-035 Reset, write 0..15 on 16 consecutive cycles -> almost_full=1 after 12th write, full=1, count=16 after 16th; 17th write -> overflow=1, count=16.
REQ-036 FWFT=0, from full, rd 16 cycles -> rdata 0..15 each one cycle after its rd, rvalid pulses each; empty=1 after last; extra rd -> underflow=1, rvalid=0.
REQ-037 count=5, rd=wr=1 for 40 cycles -> count stays 5, read sequence equals write sequence, pointers wrap twice.
REQ-038 empty, rd=wr=1 with wdata=0x3C -> count=1, underflow=1, rvalid=0; clr_err one cycle -> underflow=0.
REQ-039 count=9, resetn=0 for one edge -> count=0, empty=1, flags 0; next write 0x77 then read -> rdata=0x77 only.
REQ-040 FWFT=1, write 0xA5 at edge N -> rdata=0xA5, rvalid=1 after edge N; rd=1 at edge N+1 -> empty=1, rvalid=0.
